// File: rtl/common_dffram_nwnr_pkg.sv
// Shared sizing helpers for the multi-port DFF RAM and its per-entry write merge.
package common_dffram_nwnr_pkg;

   function automatic int unsigned dffram_aw(input int unsigned onehot, input int unsigned depth);
      return (onehot != 0) ? depth : $clog2(depth);
   endfunction

   function automatic int unsigned dffram_wew(input int unsigned bitwe, input int unsigned width);
      return (bitwe != 0) ? width : 1;
   endfunction

endpackage

// File: rtl/common_dffram_nwnr_wmerge.sv
// Per-entry write merge: applies every selected port in index order so the
// highest-index port wins each bit; nxt_o doubles as the write-first bypass value.
module common_dffram_nwnr_wmerge
   import common_dffram_nwnr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NW    = 2
) (
   input  logic [WIDTH-1:0]    cur_i,
   input  logic [NW-1:0]       sel_i,
   input  logic [NW*WIDTH-1:0] mask_i,
   input  logic [NW*WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0]    nxt_o,
   output logic                hit_o
);

   always_comb begin
      nxt_o = cur_i;
      hit_o = 1'b0;
      for (int unsigned w = 0; w < NW; w++) begin
         if (sel_i[w]) begin
            nxt_o = (nxt_o & ~mask_i[WIDTH*w +: WIDTH]) |
                    (wdata_i[WIDTH*w +: WIDTH] & mask_i[WIDTH*w +: WIDTH]);
            hit_o = hit_o | (|mask_i[WIDTH*w +: WIDTH]);
         end
      end
   end

endmodule

// File: rtl/common_dffram_nwnr.sv
// Parametrised DFF RAM: NW prioritised write ports, NR independent read ports,
// optional write-first bypass, per-entry valid bits with global flush.
module common_dffram_nwnr
   import common_dffram_nwnr_pkg::*;
#(
   parameter int unsigned                      RAM_WIDTH         = 8,
   parameter int unsigned                      RAM_DEPTH         = 8,
   parameter logic [RAM_DEPTH*RAM_WIDTH-1:0]   RAM_RESET_VALUE   = '0,
   parameter int unsigned                      NW                = 2,
   parameter int unsigned                      NR                = 2,
   parameter int unsigned                      ONEHOT_ADDRESSING = 0,
   parameter int unsigned                      BIT_WRITE_ENABLE  = 0,
   parameter int unsigned                      READ_LATENCY      = 0,
   parameter int unsigned                      READ_BYPASS       = 0,
   localparam int unsigned                     AW  = dffram_aw(ONEHOT_ADDRESSING, RAM_DEPTH),
   localparam int unsigned                     WEW = dffram_wew(BIT_WRITE_ENABLE, RAM_WIDTH)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NW-1:0]           wen,
   input  logic [NW*AW-1:0]        waddr,
   input  logic [NW*WEW-1:0]       wbe,
   input  logic [NW*RAM_WIDTH-1:0] wdata,
   input  logic [NR-1:0]           ren,
   input  logic [NR*AW-1:0]        raddr,
   output logic [NR*RAM_WIDTH-1:0] rdata,
   output logic [NR-1:0]           rvalid,
   input  logic                    flush
);

   logic [RAM_WIDTH-1:0]    mem_q [RAM_DEPTH];
   logic [RAM_WIDTH-1:0]    mem_d [RAM_DEPTH];
   logic [RAM_DEPTH-1:0]    valid_q;
   logic [RAM_DEPTH-1:0]    valid_d;
   logic [RAM_DEPTH-1:0]    whit;
   logic [RAM_DEPTH*NW-1:0] wsel;
   logic [NW*RAM_WIDTH-1:0] wmask;

   for (genvar w = 0; w < NW; w++) begin : g_wport
      logic [AW-1:0] wa;
      assign wa = waddr[AW*w +: AW];
      if (WEW == 1) begin : g_word
         assign wmask[RAM_WIDTH*w +: RAM_WIDTH] = {RAM_WIDTH{wbe[w]}};
      end else begin : g_bit
         assign wmask[RAM_WIDTH*w +: RAM_WIDTH] = wbe[WEW*w +: WEW];
      end
      for (genvar e = 0; e < RAM_DEPTH; e++) begin : g_dec
         if (ONEHOT_ADDRESSING != 0) begin : g_oh
            assign wsel[NW*e + w] = wen[w] & wa[e];
         end else begin : g_bin
            assign wsel[NW*e + w] = wen[w] & (wa == AW'(e));
         end
      end
   end

   for (genvar e = 0; e < RAM_DEPTH; e++) begin : g_entry
      common_dffram_nwnr_wmerge #(
         .WIDTH (RAM_WIDTH),
         .NW    (NW)
      ) u_wmerge (
         .cur_i   (mem_q[e]),
         .sel_i   (wsel[NW*e +: NW]),
         .mask_i  (wmask),
         .wdata_i (wdata),
         .nxt_o   (mem_d[e]),
         .hit_o   (whit[e])
      );
      // a same-cycle write re-validates its entry even under flush
      assign valid_d[e] = whit[e] | (valid_q[e] & ~flush);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
            mem_q[i] <= RAM_RESET_VALUE[RAM_WIDTH*i +: RAM_WIDTH];
         end
         valid_q <= '0;
      end else begin
         for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         valid_q <= valid_d;
      end
   end

   for (genvar r = 0; r < NR; r++) begin : g_rport
      logic [AW-1:0]        ra;
      logic [RAM_DEPTH-1:0] rsel;
      logic [RAM_WIDTH-1:0] rd_c;
      logic                 rv_c;

      assign ra = raddr[AW*r +: AW];
      for (genvar e = 0; e < RAM_DEPTH; e++) begin : g_dec
         if (ONEHOT_ADDRESSING != 0) begin : g_oh
            assign rsel[e] = ra[e];
         end else begin : g_bin
            assign rsel[e] = (ra == AW'(e));
         end
      end

      always_comb begin
         rd_c = '0;
         rv_c = 1'b0;
         for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
            if (rsel[i]) begin
               rd_c = rd_c | ((READ_BYPASS != 0) ? mem_d[i] : mem_q[i]);
               rv_c = rv_c | ((READ_BYPASS != 0) ? valid_d[i] : valid_q[i]);
            end
         end
      end

      if (READ_LATENCY != 0) begin : g_reg
         logic [RAM_WIDTH-1:0] rdata_q;
         logic                 rvalid_q;
         always_ff @(posedge clk) begin
            if (!resetn) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else if (ren[r]) begin
               rdata_q  <= rd_c;
               rvalid_q <= rv_c;
            end
         end
         assign rdata[RAM_WIDTH*r +: RAM_WIDTH] = rdata_q;
         assign rvalid[r]                       = rvalid_q;
      end else begin : g_comb
         assign rdata[RAM_WIDTH*r +: RAM_WIDTH] = rd_c;
         assign rvalid[r]                       = rv_c;
      end
   end

   if (READ_LATENCY == 0) begin : g_no_ren
      logic unused_ren;
      assign unused_ren = ^ren;
   end

endmodule

// File: doc/common_dffram_nwnr.md
Name: common_dffram_nwnr

Overview:
- Parametrised DFF-based multi-port RAM / register file.
- Generalises the single-write, two-read DFF RAM in three ways:
  - NW write ports with fixed priority.
  - NR read ports, each selectable as combinational or registered.
  - Optional write-first bypass, plus per-entry valid bits with a global flush.
- Intended for rename tables, small tag stores and register files in Taurus pipelines.

Parameters:
- RAM_WIDTH, 8: data bits per entry.
- RAM_DEPTH, 8: number of entries, >=2; need not be a power of two.
- RAM_RESET_VALUE, all zero: packed initial contents, RAM_DEPTH*RAM_WIDTH bits, entry i at [RAM_WIDTH*i +: RAM_WIDTH].
- NW, 2: number of write ports, 1..4.
- NR, 2: number of read ports, 1..8.
- ONEHOT_ADDRESSING, 0: 1 = one-hot addresses of RAM_DEPTH bits; 0 = binary addresses of clog2(RAM_DEPTH) bits.
- BIT_WRITE_ENABLE, 0: 1 = per-bit write enable of RAM_WIDTH bits; 0 = 1-bit write enable.
- READ_LATENCY, 0: 0 = combinational read; 1 = registered read.
- READ_BYPASS, 0: 1 = write-first (same-cycle write data visible); 0 = read-first.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- wen  in  NW  per-port write enable.
- waddr  in  NW*AW  packed write addresses (AW = address width).
- wbe  in  NW*WEW  packed bit/word enables (WEW = RAM_WIDTH or 1).
- wdata  in  NW*RAM_WIDTH  packed write data.
- ren  in  NR  read enable; used only when READ_LATENCY=1.
- raddr  in  NR*AW  packed read addresses.
- rdata  out  NR*RAM_WIDTH  read data.
- rvalid  out  NR  valid bit of the addressed entry.
- flush  in  1  clear all valid bits.

Behaviour:
- Reset, on a clk edge with resetn=0:
  - Entry i loads RAM_RESET_VALUE[i].
  - All valid bits clear to 0.
  - Registered rdata/rvalid clear to 0.
  - Writes and flush are ignored that cycle.
- Write, per edge:
  - Entry bit b updates when wen[w], the address decodes to the entry, and the corresponding wbe bit is 1.
  - Multiple ports hitting the same bit: the highest-index port wins. Arbitration is per bit when BIT_WRITE_ENABLE=1.
  - Any write with a nonzero enable sets that entry's valid bit.
- Flush: clears every valid bit. A write in the same cycle still sets its own entry's valid bit (write beats flush). Data contents are unaffected.
- Out-of-range binary address (>= RAM_DEPTH): write ignored; read returns rdata=0, rvalid=0.
- One-hot addressing: an all-zero address reads 0 and writes nothing. Multi-hot reads return the OR of the selected entries; multi-hot writes update every selected entry.
- READ_LATENCY=0:
  - rdata/rvalid are purely combinational from raddr and current state.
  - With READ_BYPASS=1 they additionally reflect this cycle's winning writes, merged per bit.
  - With READ_BYPASS=1 and flush=1, rvalid=0 unless bypassed by a same-cycle write.
- READ_LATENCY=1:
  - ren=1: the output registers capture on the edge.
    - READ_BYPASS=1 captures the post-write/post-flush value (write-first).
    - READ_BYPASS=0 captures the pre-edge value (read-first).
  - ren=0: outputs hold.
- Read ports are fully independent; there is no structural hazard and no stall.

Decomposition:
- Shared header common_dffram_defs.vh:
  - Address-width function (onehot ? DEPTH : clog2).
  - WEW function.
  - Port-slice helper macros.
- One sub-module, common_dffram_wmerge:
  - Per-entry priority merge of NW ports.
  - Outputs the next-entry value, a write-hit flag and the merged bypass data.
  - Instantiated RAM_DEPTH times.
- Existing one-hot decoder and OR-reduction macros are reused for address decode and read muxing.

Test Plan:
1. Reset with DEPTH=8, RESET_VALUE entry3=0xA5, LATENCY=0: raddr0=3 -> rdata0=0xA5, rvalid0=0. After resetn release, write port0 addr3 data 0x11 -> next cycle rdata0=0x11, rvalid0=1.
2. Priority, NW=2, same addr 5, wdata0=0x0F, wdata1=0xF0: entry5=0xF0. With BIT_WRITE_ENABLE=1, wbe0=0xFF, wbe1=0x0F -> entry5=0x00 (bits 3:0 from port1 = 0x0, bits 7:4 from port0 = 0x0); with wdata1=0xFF instead -> entry5=0x0F.
3. Bypass, LATENCY=0, entry2=0x33, same-cycle write 0x44 to 2:
   - BYPASS=1 -> rdata=0x44 that cycle.
   - BYPASS=0 -> 0x33 that cycle, 0x44 next cycle.
4. Registered read, LATENCY=1, BYPASS=0:
   - ren=1 with raddr=2 while writing 0x55 to 2 -> next cycle rdata=old value.
   - ren=0 for 3 cycles -> rdata holds.
5. Flush + write: entries 0..3 valid; flush=1 with a write to 1 -> afterwards rvalid for entry 1=1, entries 0, 2, 3=0, data unchanged.
6. DEPTH=6 binary: write to addr 7 -> no entry changes; raddr=6 -> rdata=0, rvalid=0. Reset mid-burst of writes -> all contents return to RESET_VALUE.
